// File: rtl/mouse_pkg.sv
// Shared types and default constants for the mouse event generator.
package mouse_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOWN1 = 3'd1,
        LONG  = 3'd2,
        WAIT2 = 3'd3,
        DOWN2 = 3'd4
    } click_state_t;

    // Defaults assume a 75 MHz pixel clock: 300 ms double-click gap, 1 s long press.
    localparam int DBL_CLICK_CYC_DEF  = 22500000;
    localparam int LONG_PRESS_CYC_DEF = 75000000;

    localparam int H_MAX_DEF = 1023;
    localparam int V_MAX_DEF = 767;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level signals, parametrised width.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/mouse_event_gen.sv
// Mouse sampling stage: synchronise position/buttons, clamp and grid-map, button-0 gestures.
// Define MOUSE_DRAG_EN to add drag_active/drag_dx/drag_dy. Release pulses use port rel.
module mouse_event_gen
    import mouse_pkg::*;
#(
    parameter int POS_W          = 12,
    parameter int NBTN           = 3,
    parameter int H_MAX          = H_MAX_DEF,
    parameter int V_MAX          = V_MAX_DEF,
    parameter int CELL_LOG2      = 4,
    parameter int DBL_CLICK_CYC  = DBL_CLICK_CYC_DEF,
    parameter int LONG_PRESS_CYC = LONG_PRESS_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [POS_W-1:0]       x_in,
    input  logic [POS_W-1:0]       y_in,
    input  logic [NBTN-1:0]        btn_in,
    input  logic                   evt_tgl,
    output logic [POS_W-1:0]       x,
    output logic [POS_W-1:0]       y,
    output logic [POS_W-CELL_LOG2-1:0] col,
    output logic [POS_W-CELL_LOG2-1:0] row,
    output logic                   moved,
    output logic [NBTN-1:0]        held,
    output logic [NBTN-1:0]        press,
    output logic [NBTN-1:0]        rel,
    output logic                   click,
    output logic                   dbl_click,
    output logic                   long_press,
    output logic [2:0]             click_state
`ifdef MOUSE_DRAG_EN
    ,
    output logic                   drag_active,
    output logic signed [POS_W:0]  drag_dx,
    output logic signed [POS_W:0]  drag_dy
`endif
);

    localparam int CNT_W = $clog2(max_int(DBL_CLICK_CYC, LONG_PRESS_CYC)) + 1;

    // Event toggle: two synchroniser flops plus a local third for edge detection.
    logic [0:0] tgl_s2;
    logic       tgl_s3;
    logic       evt;

    sync_2ff #(.W(1)) u_sync_tgl (
        .clk (clk),
        .rst (rst),
        .d   (evt_tgl),
        .q   (tgl_s2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tgl_s3 <= 1'b0;
        else     tgl_s3 <= tgl_s2[0];
    end

    assign evt = tgl_s2[0] ^ tgl_s3;

    // x_in/y_in are held stable by the source while the toggle is in flight.
    logic [POS_W-1:0] x_clamp;
    logic [POS_W-1:0] y_clamp;

    assign x_clamp = (x_in > POS_W'(H_MAX)) ? POS_W'(H_MAX) : x_in;
    assign y_clamp = (y_in > POS_W'(V_MAX)) ? POS_W'(V_MAX) : y_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            col   <= '0;
            row   <= '0;
            moved <= 1'b0;
        end else begin
            moved <= 1'b0;
            if (evt) begin
                x     <= x_clamp;
                y     <= y_clamp;
                col   <= x_clamp[POS_W-1:CELL_LOG2];
                row   <= y_clamp[POS_W-1:CELL_LOG2];
                moved <= (x_clamp != x) || (y_clamp != y);
            end
        end
    end

    logic [NBTN-1:0] held_q;

    sync_2ff #(.W(NBTN)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (held)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
            press  <= '0;
            rel    <= '0;
        end else begin
            held_q <= held;
            press  <= held & ~held_q;
            rel    <= ~held & held_q;
        end
    end

    // Button-0 gesture FSM; one counter serves both the hold and the gap timer.
    click_state_t     state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            click      <= 1'b0;
            dbl_click  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            click      <= 1'b0;
            dbl_click  <= 1'b0;
            long_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (press[0]) begin
                        state <= DOWN1;
                        cnt   <= '0;
                    end
                end
                DOWN1: begin
                    if (rel[0]) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LONG_PRESS_CYC - 1)) begin
                        long_press <= 1'b1;
                        state      <= LONG;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (rel[0]) state <= IDLE;
                end
                WAIT2: begin
                    // A press on the timeout cycle still counts as a double click.
                    if (press[0]) begin
                        dbl_click <= 1'b1;
                        state     <= DOWN2;
                    end else if (cnt == CNT_W'(DBL_CLICK_CYC - 1)) begin
                        click <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DOWN2: begin
                    if (rel[0]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign click_state = state;

`ifdef MOUSE_DRAG_EN
    logic [POS_W-1:0] anchor_x;
    logic [POS_W-1:0] anchor_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anchor_x    <= '0;
            anchor_y    <= '0;
            drag_active <= 1'b0;
            drag_dx     <= '0;
            drag_dy     <= '0;
        end else if (press[0]) begin
            anchor_x    <= x;
            anchor_y    <= y;
            drag_active <= 1'b1;
            drag_dx     <= '0;
            drag_dy     <= '0;
        end else if (rel[0]) begin
            drag_active <= 1'b0;
        end else if (drag_active) begin
            drag_dx <= $signed({1'b0, x}) - $signed({1'b0, anchor_x});
            drag_dy <= $signed({1'b0, y}) - $signed({1'b0, anchor_y});
        end
    end
`endif

endmodule

// File: tb/tb_mouse_event_gen.sv
// Randomised self-checking bench for mouse_event_gen against a gesture-level event model.
`timescale 1ns/1ps
module tb_mouse_event_gen;
    import mouse_pkg::*;

    localparam int POS_W = 12, NBTN = 3, H_MAX = 1023, V_MAX = 767, CELL_LOG2 = 4;
    localparam int DBL = 20, LONG = 50;
    localparam int CW = POS_W - CELL_LOG2;
    localparam int EV_PRESS = 0, EV_REL = 3, EV_CLICK = 6, EV_DBL = 7, EV_LONG = 8, EV_MOVED = 9;

    logic clk, rst;
    logic [POS_W-1:0] x_in, y_in;
    logic [NBTN-1:0] btn_in;
    logic evt_tgl;
    logic [POS_W-1:0] x, y;
    logic [CW-1:0] col, row;
    logic moved, click, dbl_click, long_press;
    logic [NBTN-1:0] held, press, rel;
    logic [2:0] click_state;
`ifdef MOUSE_DRAG_EN
    logic drag_active;
    logic signed [POS_W:0] drag_dx, drag_dy;
`endif

    mouse_event_gen #(
        .POS_W(POS_W), .NBTN(NBTN), .H_MAX(H_MAX), .V_MAX(V_MAX), .CELL_LOG2(CELL_LOG2),
        .DBL_CLICK_CYC(DBL), .LONG_PRESS_CYC(LONG)
    ) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .btn_in(btn_in), .evt_tgl(evt_tgl),
        .x(x), .y(y), .col(col), .row(row), .moved(moved), .held(held), .press(press),
        .rel(rel), .click(click), .dbl_click(dbl_click), .long_press(long_press),
        .click_state(click_state)
`ifdef MOUSE_DRAG_EN
        , .drag_active(drag_active), .drag_dx(drag_dx), .drag_dy(drag_dy)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef logic [NBTN-1:0] lvl_t;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    lvl_t plan_q[$];
    int n_checks = 0;
    int n_fail = 0;
    logic [POS_W-1:0] mx, my;

    function automatic logic [31:0] ev(input int c, input int code);
        return 32'(c * 16 + code);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Records every pulse as {cycle, event code}.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NBTN; i++) if (press[i]) obs_q.push_back(ev(cyc, EV_PRESS + i));
            for (int i = 0; i < NBTN; i++) if (rel[i])   obs_q.push_back(ev(cyc, EV_REL + i));
            if (click)      obs_q.push_back(ev(cyc, EV_CLICK));
            if (dbl_click)  obs_q.push_back(ev(cyc, EV_DBL));
            if (long_press) obs_q.push_back(ev(cyc, EV_LONG));
            if (moved)      obs_q.push_back(ev(cyc, EV_MOVED));
        end
    end

    task automatic cmp_events(input string tag);
        int n;
        check({tag, "_nev"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, obs_q[i], exp_q[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic add_seg(input lvl_t lvl, input int n);
        for (int i = 0; i < n; i++) plan_q.push_back(lvl);
    endtask

    task automatic make_random();
        int nseg, hold, gap;
        logic b1, b2;
        b1 = 1'b0; b2 = 1'b0;
        nseg = $urandom_range(3, 6);
        for (int s = 0; s < nseg; s++) begin
            case ($urandom_range(0, 2))
                0:       hold = $urandom_range(1, 8);
                1:       hold = $urandom_range(9, 45);
                default: hold = $urandom_range(46, 70);
            endcase
            gap = $urandom_range(1, 30);
            for (int k = 0; k < hold + gap; k++) begin
                if ($urandom_range(0, 7) == 0)  b1 = ~b1;
                if ($urandom_range(0, 15) == 0) b2 = ~b2;
                plan_q.push_back({b2, b1, (k < hold) ? 1'b1 : 1'b0});
            end
        end
        add_seg('0, 5);
    endtask

    // Drives plan_q (one level per cycle) and checks all button events against the model.
    task automatic run_btn(input string tag);
        int start, j;
        lvl_t prev, cur;
        int pr[$];
        int rl[$];
        obs_q.delete();
        exp_q.delete();
        start = 0;
        for (int k = 0; k < plan_q.size(); k++) begin
            @(posedge clk); #1;
            if (k == 0) start = cyc;
            btn_in = plan_q[k];
        end
        repeat (DBL + 15) @(posedge clk);
        @(negedge clk);
        // A level change driven in cycle n gives its pulse in cycle n+3.
        prev = '0;
        for (int k = 0; k < plan_q.size(); k++) begin
            cur = plan_q[k];
            for (int b = 0; b < NBTN; b++) begin
                if (cur[b] && !prev[b]) begin
                    exp_q.push_back(ev(start + k + 3, EV_PRESS + b));
                    if (b == 0) pr.push_back(start + k + 3);
                end
                if (!cur[b] && prev[b]) begin
                    exp_q.push_back(ev(start + k + 3, EV_REL + b));
                    if (b == 0) rl.push_back(start + k + 3);
                end
            end
            prev = cur;
        end
        // Gesture rules on button-0 press/release pulse times.
        j = 0;
        while (j < pr.size()) begin
            if (rl[j] > pr[j] + LONG) begin
                exp_q.push_back(ev(pr[j] + LONG + 1, EV_LONG));
                j++;
            end else if (j + 1 < pr.size() && pr[j+1] - rl[j] <= DBL) begin
                exp_q.push_back(ev(pr[j+1] + 1, EV_DBL));
                j += 2;
            end else begin
                exp_q.push_back(ev(rl[j] + DBL + 1, EV_CLICK));
                j++;
            end
        end
        exp_q.sort();
        cmp_events(tag);
        plan_q.delete();
    endtask

    task automatic send_pos(input logic [POS_W-1:0] nx, input logic [POS_W-1:0] ny);
        logic [POS_W-1:0] ex, ey;
        logic exp_mv;
        int t0;
        ex = (nx > POS_W'(H_MAX)) ? POS_W'(H_MAX) : nx;
        ey = (ny > POS_W'(V_MAX)) ? POS_W'(V_MAX) : ny;
        exp_mv = (ex != mx) || (ey != my);
        @(posedge clk); #1;
        obs_q.delete();
        x_in = nx; y_in = ny; evt_tgl = ~evt_tgl;
        t0 = cyc;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("pos_x", 32'(x), 32'(ex));
        check("pos_y", 32'(y), 32'(ey));
        check("pos_col", 32'(col), 32'(ex / 16));
        check("pos_row", 32'(row), 32'(ey / 16));
        check("moved_cnt", 32'(obs_q.size()), exp_mv ? 32'd1 : 32'd0);
        if (obs_q.size() == 1 && exp_mv) check("moved_cyc", obs_q[0], ev(t0 + 3, EV_MOVED));
        mx = ex; my = ey;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; btn_in = '0; evt_tgl = 1'b0; x_in = '0; y_in = '0;
        mx = '0; my = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_pos", {8'd0, x, y}, 32'd0);
        check("rst_grid", {16'd0, col, row}, 32'd0);
        check("rst_btn", {23'd0, held, press, rel}, 32'd0);
        check("rst_evt", {28'd0, moved, click, dbl_click, long_press}, 32'd0);
        check("rst_state", 32'(click_state), 32'(IDLE));

        // Reset mid-gesture.
        @(posedge clk); #1 btn_in = 3'b001;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_rst_state", 32'(click_state), 32'(DOWN1));
        @(posedge clk); #1 rst = 1'b1; btn_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(click_state), 32'(IDLE));
        check("midrst_btn", {23'd0, held, press, rel}, 32'd0);
        check("midrst_evt", {28'd0, moved, click, dbl_click, long_press}, 32'd0);
        obs_q.delete();
        repeat (DBL + 40) @(posedge clk);
        @(negedge clk);
        check("midrst_no_evt", 32'(obs_q.size()), 32'd0);

        // Position: clamp, grid mapping, moved only on change.
        send_pos(12'd2000, 12'd100);
        send_pos(12'd2000, 12'd100);
        send_pos(12'd1023, 12'd767);
        send_pos(12'd4095, 12'd4095);
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) send_pos(x_in, y_in);
            else send_pos(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        end

        // Synchronised levels.
        @(posedge clk); #1 btn_in = 3'b101;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_101", 32'(held), 32'b101);
        @(posedge clk); #1 btn_in = '0;
        repeat (DBL + 40) @(posedge clk);

        // Directed gestures.
        add_seg(3'b001, 5); add_seg('0, 35);
        run_btn("click");
        add_seg(3'b001, 5); add_seg('0, 10); add_seg(3'b001, 5); add_seg('0, 30);
        run_btn("dbl");
        add_seg(3'b001, 80); add_seg('0, 30);
        run_btn("long");
        add_seg(3'b001, 2); add_seg(3'b011, 3); add_seg(3'b010, 2); add_seg('0, 35);
        run_btn("btn1_mix");
        add_seg(3'b001, 5); add_seg('0, 17); add_seg(3'b001, 3); add_seg('0, 30);
        run_btn("dbl_edge");
        add_seg(3'b001, 5); add_seg('0, 18); add_seg(3'b001, 3); add_seg('0, 30);
        run_btn("dbl_late");
        add_seg(3'b001, 50); add_seg('0, 30);
        run_btn("long_edge");

        for (int r = 0; r < 8; r++) begin
            make_random();
            run_btn("rand");
        end

`ifdef MOUSE_DRAG_EN
        send_pos(12'd100, 12'd100);
        @(posedge clk); #1 btn_in = 3'b001;
        repeat (6) @(posedge clk);
        send_pos(12'd90, 12'd130);
        check("drag_active", 32'(drag_active), 32'd1);
        check("drag_dx", 32'(drag_dx), 32'(-10));
        check("drag_dy", 32'(drag_dy), 32'd30);
        @(posedge clk); #1 btn_in = '0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drag_off", 32'(drag_active), 32'd0);
        check("drag_dx_hold", 32'(drag_dx), 32'(-10));
        repeat (DBL + 40) @(posedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
